// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serialising RAM controller.
package mem_ctrl_pkg;

    // Transfer size encodings on req_size (3 is treated as a word).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    // Number of RAM byte accesses needed for a given transfer size.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_lane.sv
// Byte-lane datapath: picks the store byte to drive onto the RAM and
// applies the final sign/zero extension to assembled load data.
module mem_ctrl_lane
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_sel,
    output logic [7:0]  wbyte,
    input  logic [31:0] raw_data,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ext_data
);

    // Select store byte k (little-endian: byte 0 is bits [7:0]).
    always_comb begin
        wbyte = 8'd0;
        case (byte_sel)
            2'd0:    wbyte = wdata[7:0];
            2'd1:    wbyte = wdata[15:8];
            2'd2:    wbyte = wdata[23:16];
            2'd3:    wbyte = wdata[31:24];
            default: wbyte = 8'd0;
        endcase
    end

    // Extend from the top fetched byte; words pass through untouched.
    always_comb begin
        ext_data = raw_data;
        case (size)
            SZ_BYTE: ext_data = {{24{is_signed & raw_data[7]}}, raw_data[7:0]};
            SZ_HALF: ext_data = {{16{is_signed & raw_data[15]}}, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-side initiator for a byte-wide synchronous RAM. Serialises one
// byte/half/word load or store into little-endian byte accesses and
// returns a single response pulse per request.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RD   = RD;
    localparam logic [1:0] ST_WR   = WR;

    // Architectural state
    logic [1:0]            state_r;
    logic [2:0]            cnt_r;      // cycle index since handshake (issue index while < nby_r)
    logic [2:0]            nby_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [31:0]           wdata_r;
    logic [1:0]            sz_r;
    logic                  sgn_r;
    logic [31:0]           acc_r;      // read bytes captured so far

    // Registered outputs
    logic                  resp_valid_r;
    logic [31:0]           resp_rdata_r;
    logic                  ram_en_r;
    logic                  ram_r_nw_r;
    logic [ADDR_WIDTH-1:0] ram_a_r;
    logic [7:0]            ram_d_r;

    // Next-state values
    logic                  hs_s;
    logic                  done_s;
    logic [1:0]            state_nxt_s;
    logic [2:0]            cnt_nxt_s;
    logic [2:0]            nby_nxt_s;
    logic [ADDR_WIDTH-1:0] base_nxt_s;
    logic [31:0]           wdata_nxt_s;
    logic [1:0]            sz_nxt_s;
    logic                  sgn_nxt_s;
    logic [31:0]           asm_s;
    logic [31:0]           ext_s;
    logic [7:0]            wbyte_s;
    logic [ADDR_WIDTH-1:0] a_nxt_s;

    assign req_ready    = (state_r == ST_IDLE);
    assign hs_s         = req_valid & (state_r == ST_IDLE);

    assign resp_valid   = resp_valid_r;
    assign resp_rdata   = resp_rdata_r;
    assign ram_en_out   = ram_en_r;
    assign ram_r_nw_out = ram_r_nw_r;
    assign ram_a_out    = ram_a_r;
    assign ram_d_out    = ram_d_r;

    // FSM and request-latch next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        nby_nxt_s   = nby_r;
        base_nxt_s  = base_r;
        wdata_nxt_s = wdata_r;
        sz_nxt_s    = sz_r;
        sgn_nxt_s   = sgn_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = req_we ? ST_WR : ST_RD;
                    cnt_nxt_s   = 3'd0;
                    nby_nxt_s   = size_to_nbytes(req_size);
                    base_nxt_s  = req_addr;
                    wdata_nxt_s = req_wdata;
                    sz_nxt_s    = req_size;
                    sgn_nxt_s   = req_signed;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // Byte cnt_r is written on the edge that ends this cycle.
                if (cnt_r == (nby_r - 3'd1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                    done_s      = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + 3'd1;
                end
            end
            ST_RD: begin
                // One extra cycle after the last issue to capture the final byte.
                if (cnt_r == nby_r) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                    done_s      = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Merge the byte returned this cycle (issued last cycle) into the accumulator.
    always_comb begin
        asm_s = acc_r;
        if (state_r == ST_RD) begin
            case (cnt_r)
                3'd1:    asm_s[7:0]   = ram_d_in;
                3'd2:    asm_s[15:8]  = ram_d_in;
                3'd3:    asm_s[23:16] = ram_d_in;
                3'd4:    asm_s[31:24] = ram_d_in;
                default: asm_s        = acc_r;
            endcase
        end else begin
            asm_s = acc_r;
        end
    end

    // Address for the next cycle's access; wraps modulo the RAM size.
    always_comb begin
        if (state_nxt_s == ST_IDLE) begin
            a_nxt_s = {ADDR_WIDTH{1'b0}};
        end else begin
            a_nxt_s = base_nxt_s + {{(ADDR_WIDTH-3){1'b0}}, cnt_nxt_s};
        end
    end

    mem_ctrl_lane u_lane (
        .wdata     (wdata_nxt_s),
        .byte_sel  (cnt_nxt_s[1:0]),
        .wbyte     (wbyte_s),
        .raw_data  (asm_s),
        .size      (sz_r),
        .is_signed (sgn_r),
        .ext_data  (ext_s)
    );

    // State, request latches and capture register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            nby_r   <= 3'd1;
            base_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 32'd0;
            sz_r    <= SZ_BYTE;
            sgn_r   <= 1'b0;
            acc_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            nby_r   <= nby_nxt_s;
            base_r  <= base_nxt_s;
            wdata_r <= wdata_nxt_s;
            sz_r    <= sz_nxt_s;
            sgn_r   <= sgn_nxt_s;
            acc_r   <= hs_s ? 32'd0 : asm_s;
        end
    end

    // Response pulse and RAM port outputs, registered from next-state values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            ram_en_r     <= 1'b0;
            ram_r_nw_r   <= 1'b1;
            ram_a_r      <= {ADDR_WIDTH{1'b0}};
            ram_d_r      <= 8'd0;
        end else begin
            resp_valid_r <= done_s;
            resp_rdata_r <= (done_s && (state_r == ST_RD)) ? ext_s : 32'd0;
            ram_en_r     <= (state_nxt_s != ST_IDLE) && (cnt_nxt_s < nby_nxt_s);
            ram_r_nw_r   <= (state_nxt_s != ST_WR);
            ram_a_r      <= a_nxt_s;
            ram_d_r      <= (state_nxt_s == ST_WR) ? wbyte_s : 8'd0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of requests issued back to back,
// scoreboard queues for expected RAM writes and responses, plus
// hand-written reset sequences.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          ram_en_out;
    logic          ram_r_nw_out;
    logic [AW-1:0] ram_a_out;
    logic [7:0]    ram_d_out;
    logic [7:0]    ram_d_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } resp_t;

    wr_t   wr_q[$];
    resp_t resp_q[$];
    wr_t   mw;
    resp_t mr;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural byte RAM with one-cycle synchronous read.
    logic [7:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_en_out) begin
            if (ram_r_nw_out) ram_d_in <= mem[ram_a_out];
            else              mem[ram_a_out] <= ram_d_out;
        end
    end

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .ram_en_out   (ram_en_out),
        .ram_r_nw_out (ram_r_nw_out),
        .ram_a_out    (ram_a_out),
        .ram_d_out    (ram_d_out),
        .ram_d_in     (ram_d_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst && ram_en_out && !ram_r_nw_out) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {15'd0, ram_a_out}, 32'hFFFFFFFF);
            end else begin
                mw = wr_q.pop_front();
                chk("wr_addr", {15'd0, ram_a_out}, {15'd0, mw.a});
                chk("wr_data", {24'd0, ram_d_out}, {24'd0, mw.d});
            end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", resp_rdata, 32'hFFFFFFFF);
            end else begin
                mr = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, mr.rdata);
                chk("resp_cycle", cyc, mr.due);
            end
        end
    end

    // Present one request, wait for acceptance, and queue its expected effects.
    task automatic issue(input vec_t v, output logic resp_at_accept);
        int   n;
        int   lat;
        int   waits;
        wr_t  w;
        resp_t r;
        resp_at_accept = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        waits = 0;
        while (!req_ready && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        resp_at_accept = resp_valid;
        n   = (v.size == 2'd0) ? 1 : ((v.size == 2'd1) ? 2 : 4);
        lat = v.we ? n : n + 1;
        if (v.we) begin
            for (int k = 0; k < n; k++) begin
                w.a = v.addr + AW'(k);
                w.d = v.wdata[8*k +: 8];
                wr_q.push_back(w);
            end
        end
        r.rdata = v.we ? 32'd0 : v.exp;
        r.due   = cyc + 1 + lat;
        resp_q.push_back(r);
        @(posedge clk);
    endtask

    task automatic drain();
        int waits = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk("drain_resp_q", resp_q.size(), 32'd0);
        chk("drain_wr_q", wr_q.size(), 32'd0);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_en"}, {31'd0, ram_en_out}, 32'd0);
        chk({nm, "_r_nw"}, {31'd0, ram_r_nw_out}, 32'd1);
        chk({nm, "_a"}, {15'd0, ram_a_out}, 32'd0);
        chk({nm, "_d"}, {24'd0, ram_d_out}, 32'd0);
    endtask

    vec_t vecs[$];
    vec_t v;
    logic had_resp;

    initial begin
        // we, size, signed, addr, wdata, expected rdata
        vecs.push_back('{1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEADBEEF, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h00100, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 17'h00103, 32'h0,        32'hFFFFFFDE});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 17'h00103, 32'h0,        32'h000000DE});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h00102, 32'h0,        32'hFFFFDEAD});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 17'h1FFFF, 32'h00001234, 32'h00000000});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 17'h1FFFF, 32'h0,        32'h00001234});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h1FFFE, 32'h0,        32'h00123400});
        vecs.push_back('{1'b1, 2'd0, 1'b1, 17'h00200, 32'hFFFFFF80, 32'h00000000});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 17'h00200, 32'h0,        32'hFFFFFF80});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h00200, 32'h0,        32'h00000080});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 17'h00300, 32'hA5B6C7D8, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 17'h00300, 32'h0,        32'hA5B6C7D8});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 17'h00302, 32'h0,        32'h0000A5B6});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h1FFFF, 32'h0,        32'h00001234});

        // Reset values
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_release");

        // Table, issued with req_valid held high: every accept after the
        // first must land on the cycle the previous response pulses.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], had_resp);
            if (i > 0) chk($sformatf("no_bubble_%0d", i), {31'd0, had_resp}, 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();
        @(negedge clk);
        chk_idle("post_table");

        // Back-to-back load then store byte
        v = '{1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, 32'hDEADBEEF};
        issue(v, had_resp);
        v = '{1'b1, 2'd0, 1'b0, 17'h00400, 32'h0000005A, 32'h0};
        issue(v, had_resp);
        chk("b2b_accept_on_resp", {31'd0, had_resp}, 32'd1);
        v = '{1'b0, 2'd0, 1'b0, 17'h00400, 32'h0, 32'h0000005A};
        issue(v, had_resp);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset mid-load, after E2
        v = '{1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, 32'hDEADBEEF};
        issue(v, had_resp);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_idle("mid_reset");
        resp_q.delete();
        wr_q.delete();
        repeat (3) @(negedge clk);
        chk("reset_no_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        issue(v, had_resp);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
